// File: rtl/crc_engine_if.sv
// Signal bundle between the tag datapath and crc_engine: frame input, verdict and
// serial CRC output. The datapath drives the master side; the engine takes the slave side.
interface crc_engine_if #(
    parameter int WIDTH = 5
) ();
    logic             start;
    logic             bit_valid;
    logic             bit_in;
    logic             frame_end;
    logic             shift_out_req;
    logic             out_ready;
    logic [WIDTH-1:0] crc;
    logic [15:0]      bit_count;
    logic             crc_done;
    logic             crc_ok;
    logic             bit_out;
    logic             bit_out_valid;
    logic             out_done;
    logic             busy;

    modport master (
        output start, bit_valid, bit_in, frame_end, shift_out_req, out_ready,
        input  crc, bit_count, crc_done, crc_ok, bit_out, bit_out_valid, out_done, busy
    );

    modport slave (
        input  start, bit_valid, bit_in, frame_end, shift_out_req, out_ready,
        output crc, bit_count, crc_done, crc_ok, bit_out, bit_out_valid, out_done, busy
    );
endinterface

// File: rtl/crc_engine.sv
// Parametrised bit-serial CRC generator/checker (Galois, MSB-out) with a frame bit
// counter, end-of-frame verdict and MSB-first valid/ready serialiser for the CRC.
//
// state | meaning
// IDLE  | no frame open; crc and bit_count hold the last result
// ACCUM | frame open; each bit_valid advances the LFSR and counter
// SHIFT | serialising the CRC snapshot MSB-first over bit_out/out_ready
module crc_engine #(
    parameter int              WIDTH      = 5,
    parameter logic [WIDTH-1:0] POLY      = 'h09,
    parameter logic [WIDTH-1:0] PRESET    = 'h09,
    parameter logic [WIDTH-1:0] RESIDUE   = 'h00,
    parameter bit              INVERT_OUT = 1'b0
) (
    input  logic        crcinclk,
    input  logic        masterreset_n,
    crc_engine_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] OUT_MASK = {WIDTH{INVERT_OUT}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] crc_q, crc_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             ok_q, ok_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [5:0]       idx_q, idx_d;
    logic             odone_q, odone_d;

    logic             fb;
    logic [WIDTH-1:0] crc_step;
    logic [15:0]      cnt_step;
    logic             fold_en;
    logic [WIDTH-1:0] fold_crc;
    logic [15:0]      fold_cnt;

    // A same-cycle data bit is folded in before frame_end / shift_out_req look at the register.
    always_comb begin
        fb       = bus.bit_in ^ crc_q[WIDTH-1];
        crc_step = (crc_q << 1) ^ (fb ? POLY : '0);
        cnt_step = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        fold_en  = (state_q == ACCUM) && bus.bit_valid;
        fold_crc = fold_en ? crc_step : crc_q;
        fold_cnt = fold_en ? cnt_step : cnt_q;
    end

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        ok_d    = ok_q;
        done_d  = 1'b0;
        sh_d    = sh_q;
        idx_d   = idx_q;
        odone_d = 1'b0;

        if (bus.start) begin
            state_d = ACCUM;
            crc_d   = PRESET;
            cnt_d   = 16'd0;
            ok_d    = 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (bus.frame_end) begin
                        crc_d   = fold_crc;
                        cnt_d   = fold_cnt;
                        ok_d    = (fold_crc == RESIDUE) && (fold_cnt >= 16'(WIDTH));
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (bus.shift_out_req) begin
                        crc_d   = fold_crc;
                        cnt_d   = fold_cnt;
                        sh_d    = fold_crc ^ OUT_MASK;
                        idx_d   = 6'd0;
                        state_d = SHIFT;
                    end else if (bus.bit_valid) begin
                        crc_d = fold_crc;
                        cnt_d = fold_cnt;
                    end
                end
                IDLE: begin
                    if (bus.shift_out_req) begin
                        sh_d    = crc_q ^ OUT_MASK;
                        idx_d   = 6'd0;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.out_ready) begin
                        sh_d = sh_q << 1;
                        if (idx_q == 6'(WIDTH - 1)) begin
                            odone_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_q + 6'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge crcinclk) begin
        if (!masterreset_n) begin
            state_q <= IDLE;
            crc_q   <= PRESET;
            cnt_q   <= 16'd0;
            ok_q    <= 1'b0;
            done_q  <= 1'b0;
            sh_q    <= '0;
            idx_q   <= 6'd0;
            odone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            ok_q    <= ok_d;
            done_q  <= done_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            odone_q <= odone_d;
        end
    end

    assign bus.crc           = crc_q;
    assign bus.bit_count     = cnt_q;
    assign bus.crc_done      = done_q;
    assign bus.crc_ok        = ok_q;
    assign bus.bit_out       = sh_q[WIDTH-1];
    assign bus.bit_out_valid = (state_q == SHIFT);
    assign bus.out_done      = odone_q;
    assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_crc_engine.sv
// Directed bench for crc_engine: a default CRC5 instance and a CRC16 instance
// sharing clock and reset, each scenario task checking against hand-derived values.
module tb_crc_engine;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    crc_engine_if #(.WIDTH(5))  b5  ();
    crc_engine_if #(.WIDTH(16)) b16 ();

    crc_engine u_crc5 (
        .crcinclk      (clk),
        .masterreset_n (rst_n),
        .bus           (b5)
    );

    crc_engine #(
        .WIDTH      (16),
        .POLY       (16'h1021),
        .PRESET     (16'hFFFF),
        .RESIDUE    (16'h1D0F),
        .INVERT_OUT (1'b1)
    ) u_crc16 (
        .crcinclk      (clk),
        .masterreset_n (rst_n),
        .bus           (b16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed5(input logic [15:0] v, input int n, input bit end_frame);
        for (int i = 0; i < n; i++) begin
            b5.bit_valid = 1'b1;
            b5.bit_in    = v[n-1-i];
            b5.frame_end = end_frame && (i == n - 1);
            tick();
        end
        b5.bit_valid = 1'b0;
        b5.bit_in    = 1'b0;
        b5.frame_end = 1'b0;
    endtask

    task automatic feed16(input logic [87:0] v, input int n, input bit end_frame);
        for (int i = 0; i < n; i++) begin
            b16.bit_valid = 1'b1;
            b16.bit_in    = v[n-1-i];
            b16.frame_end = end_frame && (i == n - 1);
            tick();
        end
        b16.bit_valid = 1'b0;
        b16.bit_in    = 1'b0;
        b16.frame_end = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (b5.crc !== 5'h09) begin n_fail++; $display("FAIL reset_crc5: got %h want 09", b5.crc); end
        n_checks++;
        if (b16.crc !== 16'hFFFF) begin n_fail++; $display("FAIL reset_crc16: got %h want ffff", b16.crc); end
        n_checks++;
        if ({b5.bit_count, b5.crc_ok, b5.crc_done, b5.bit_out, b5.bit_out_valid, b5.out_done, b5.busy} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cnt=%0d ok=%b done=%b bo=%b bov=%b od=%b busy=%b want all 0",
                     b5.bit_count, b5.crc_ok, b5.crc_done, b5.bit_out, b5.bit_out_valid, b5.out_done, b5.busy);
        end
        rst_n = 1'b1;
        tick();
        b5.bit_valid = 1'b1;
        b5.bit_in    = 1'b1;
        b5.frame_end = 1'b1;
        tick();
        b5.bit_valid = 1'b0;
        b5.bit_in    = 1'b0;
        b5.frame_end = 1'b0;
        n_checks++;
        if (b5.crc !== 5'h09 || b5.bit_count !== 16'd0 || b5.crc_done !== 1'b0 || b5.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignore: got crc=%h cnt=%0d done=%b busy=%b want 09 0 0 0",
                     b5.crc, b5.bit_count, b5.crc_done, b5.busy);
        end
    endtask

    task automatic test_generate();
        logic [4:0] exp;
        exp = 5'b00111;
        b5.start = 1'b1;
        tick();
        b5.start = 1'b0;
        feed5(16'b1000, 4, 1'b0);
        n_checks++;
        if (b5.crc !== exp || b5.bit_count !== 16'd4) begin
            n_fail++;
            $display("FAIL gen_crc5: got crc=%b cnt=%0d want 00111 4", b5.crc, b5.bit_count);
        end
        b5.shift_out_req = 1'b1;
        b5.out_ready     = 1'b1;
        tick();
        b5.shift_out_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (b5.bit_out_valid !== 1'b1 || b5.bit_out !== exp[4-i]) begin
                n_fail++;
                $display("FAIL gen_shift_bit%0d: got v=%b b=%b want 1 %b", i, b5.bit_out_valid, b5.bit_out, exp[4-i]);
            end
            tick();
        end
        n_checks++;
        if (b5.out_done !== 1'b1 || b5.bit_out_valid !== 1'b0 || b5.crc !== exp) begin
            n_fail++;
            $display("FAIL gen_out_done: got od=%b v=%b crc=%b want 1 0 00111", b5.out_done, b5.bit_out_valid, b5.crc);
        end
        tick();
        b5.out_ready = 1'b0;
        n_checks++;
        if (b5.out_done !== 1'b0 || b5.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL gen_out_done_pulse: got od=%b busy=%b want 0 0", b5.out_done, b5.busy);
        end
    endtask

    task automatic test_check();
        b5.start = 1'b1;
        tick();
        b5.start = 1'b0;
        feed5(16'b10000011, 8, 1'b0);
        n_checks++;
        if (b5.crc_done !== 1'b0 || b5.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL chk_midframe: got done=%b busy=%b want 0 1", b5.crc_done, b5.busy);
        end
        feed5(16'b1, 1, 1'b1);
        n_checks++;
        if (b5.crc_done !== 1'b1 || b5.crc_ok !== 1'b1 || b5.crc !== 5'h00 || b5.bit_count !== 16'd9) begin
            n_fail++;
            $display("FAIL chk_good: got done=%b ok=%b crc=%h cnt=%0d want 1 1 00 9",
                     b5.crc_done, b5.crc_ok, b5.crc, b5.bit_count);
        end
        tick();
        n_checks++;
        if (b5.crc_done !== 1'b0 || b5.crc_ok !== 1'b1 || b5.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_hold: got done=%b ok=%b busy=%b want 0 1 0", b5.crc_done, b5.crc_ok, b5.busy);
        end
        b5.start = 1'b1;
        tick();
        b5.start = 1'b0;
        n_checks++;
        if (b5.crc_ok !== 1'b0) begin n_fail++; $display("FAIL chk_ok_clear: got %b want 0", b5.crc_ok); end
        feed5(16'b100100111, 9, 1'b1);
        n_checks++;
        if (b5.crc_done !== 1'b1 || b5.crc_ok !== 1'b0 || b5.crc !== 5'h13) begin
            n_fail++;
            $display("FAIL chk_bad: got done=%b ok=%b crc=%h want 1 0 13", b5.crc_done, b5.crc_ok, b5.crc);
        end
    endtask

    task automatic test_short_frame();
        b5.start = 1'b1;
        tick();
        b5.start = 1'b0;
        feed5(16'b100, 3, 1'b1);
        n_checks++;
        if (b5.crc_done !== 1'b1 || b5.crc_ok !== 1'b0 || b5.bit_count !== 16'd3 || b5.crc !== 5'h17) begin
            n_fail++;
            $display("FAIL short_frame: got done=%b ok=%b cnt=%0d crc=%h want 1 0 3 17",
                     b5.crc_done, b5.crc_ok, b5.bit_count, b5.crc);
        end
    endtask

    task automatic test_crc16_generate();
        b16.start = 1'b1;
        tick();
        b16.start = 1'b0;
        feed16({16'h0, 72'h313233343536373839}, 72, 1'b0);
        n_checks++;
        if (b16.crc !== 16'h29B1 || b16.bit_count !== 16'd72) begin
            n_fail++;
            $display("FAIL crc16_gen: got crc=%h cnt=%0d want 29b1 72", b16.crc, b16.bit_count);
        end
    endtask

    task automatic test_stall();
        logic [15:0] exp;
        logic [15:0] got;
        exp = 16'hD64E;
        got = 16'h0;
        b16.shift_out_req = 1'b1;
        b16.out_ready     = 1'b1;
        tick();
        b16.shift_out_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            got = {got[14:0], b16.bit_out};
            if (i == 5) begin
                b16.out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    n_checks++;
                    if (b16.bit_out_valid !== 1'b1 || b16.bit_out !== exp[10]) begin
                        n_fail++;
                        $display("FAIL stall_hold%0d: got v=%b b=%b want 1 %b", s, b16.bit_out_valid, b16.bit_out, exp[10]);
                    end
                end
                b16.out_ready = 1'b1;
            end
            tick();
        end
        b16.out_ready = 1'b0;
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL stall_stream: got %h want %h", got, exp); end
        n_checks++;
        if (b16.out_done !== 1'b1 || b16.bit_out_valid !== 1'b0 || b16.crc !== 16'h29B1) begin
            n_fail++;
            $display("FAIL stall_done: got od=%b v=%b crc=%h want 1 0 29b1", b16.out_done, b16.bit_out_valid, b16.crc);
        end
    endtask

    task automatic test_crc16_check();
        b16.start = 1'b1;
        tick();
        b16.start = 1'b0;
        feed16({72'h313233343536373839, 16'hD64E}, 88, 1'b1);
        n_checks++;
        if (b16.crc_done !== 1'b1 || b16.crc_ok !== 1'b1 || b16.crc !== 16'h1D0F || b16.bit_count !== 16'd88) begin
            n_fail++;
            $display("FAIL crc16_check: got done=%b ok=%b crc=%h cnt=%0d want 1 1 1d0f 88",
                     b16.crc_done, b16.crc_ok, b16.crc, b16.bit_count);
        end
    endtask

    task automatic test_abort();
        logic [15:0] exp;
        exp = 16'hE2F0;
        tick();
        b16.shift_out_req = 1'b1;
        b16.out_ready     = 1'b1;
        tick();
        b16.shift_out_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (b16.bit_out_valid !== 1'b1 || b16.bit_out !== exp[15-i]) begin
                n_fail++;
                $display("FAIL idle_shift_bit%0d: got v=%b b=%b want 1 %b", i, b16.bit_out_valid, b16.bit_out, exp[15-i]);
            end
            tick();
        end
        b16.start = 1'b1;
        tick();
        b16.start = 1'b0;
        n_checks++;
        if (b16.bit_out_valid !== 1'b0 || b16.out_done !== 1'b0 || b16.busy !== 1'b1 ||
            b16.crc !== 16'hFFFF || b16.bit_count !== 16'd0) begin
            n_fail++;
            $display("FAIL abort: got v=%b od=%b busy=%b crc=%h cnt=%0d want 0 0 1 ffff 0",
                     b16.bit_out_valid, b16.out_done, b16.busy, b16.crc, b16.bit_count);
        end
        tick();
        b16.out_ready = 1'b0;
        n_checks++;
        if (b16.out_done !== 1'b0 || b16.bit_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got od=%b v=%b want 0 0", b16.out_done, b16.bit_out_valid);
        end
    endtask

    task automatic test_priority_reset();
        b5.start     = 1'b1;
        b5.bit_valid = 1'b1;
        b5.bit_in    = 1'b1;
        tick();
        b5.start     = 1'b0;
        b5.bit_valid = 1'b0;
        b5.bit_in    = 1'b0;
        n_checks++;
        if (b5.crc !== 5'h09 || b5.bit_count !== 16'd0 || b5.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ignores_bit: got crc=%h cnt=%0d busy=%b want 09 0 1", b5.crc, b5.bit_count, b5.busy);
        end
        feed5(16'b10, 2, 1'b0);
        b5.frame_end     = 1'b1;
        b5.shift_out_req = 1'b1;
        b5.out_ready     = 1'b1;
        tick();
        b5.frame_end     = 1'b0;
        b5.shift_out_req = 1'b0;
        n_checks++;
        if (b5.crc_done !== 1'b1 || b5.crc_ok !== 1'b0 || b5.bit_out_valid !== 1'b0 ||
            b5.busy !== 1'b0 || b5.crc !== 5'h1F) begin
            n_fail++;
            $display("FAIL prio_frame_end: got done=%b ok=%b v=%b busy=%b crc=%h want 1 0 0 0 1f",
                     b5.crc_done, b5.crc_ok, b5.bit_out_valid, b5.busy, b5.crc);
        end
        tick();
        b5.out_ready = 1'b0;
        n_checks++;
        if (b5.bit_out_valid !== 1'b0 || b5.crc_done !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_no_shift: got v=%b done=%b want 0 0", b5.bit_out_valid, b5.crc_done);
        end
        b5.start = 1'b1;
        tick();
        b5.start = 1'b0;
        feed5(16'b10, 2, 1'b0);
        rst_n        = 1'b0;
        b5.bit_valid = 1'b1;
        b5.bit_in    = 1'b1;
        b5.frame_end = 1'b1;
        tick();
        b5.bit_valid = 1'b0;
        b5.bit_in    = 1'b0;
        b5.frame_end = 1'b0;
        n_checks++;
        if (b5.crc !== 5'h09 || {b5.bit_count, b5.crc_ok, b5.crc_done, b5.bit_out,
                                 b5.bit_out_valid, b5.out_done, b5.busy} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_mid_accum: got crc=%h cnt=%0d ok=%b done=%b bo=%b v=%b od=%b busy=%b want 09 and 0s",
                     b5.crc, b5.bit_count, b5.crc_ok, b5.crc_done, b5.bit_out, b5.bit_out_valid, b5.out_done, b5.busy);
        end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        b5.start = 1'b0;  b5.bit_valid = 1'b0;  b5.bit_in = 1'b0;
        b5.frame_end = 1'b0;  b5.shift_out_req = 1'b0;  b5.out_ready = 1'b0;
        b16.start = 1'b0; b16.bit_valid = 1'b0; b16.bit_in = 1'b0;
        b16.frame_end = 1'b0; b16.shift_out_req = 1'b0; b16.out_ready = 1'b0;

        test_reset();
        test_generate();
        test_check();
        test_short_frame();
        test_crc16_generate();
        test_stall();
        test_crc16_check();
        test_abort();
        test_priority_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
